// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - b_in, LSB first, one full-subtractor cell.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             brw;

  logic             diff;
  logic             brw_nxt;
  logic [WIDTH-1:0] res_nxt;

  assign diff    = sa[0] ^ sb[0] ^ brw;
  assign brw_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
  assign res_nxt = {diff, res[WIDTH-1:1]};

  assign ready = (state == IDLE);
  assign busy  = (state == RUN) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      b_out <= 1'b0;
      zero  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            brw   <= b_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_nxt;
          brw <= brw_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            done  <= 1'b1;
            d     <= res_nxt;
            b_out <= brw_nxt;
            zero  <= (res_nxt == '0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // borrow into MSB differs from borrow out of MSB
            ovf   <= brw ^ brw_nxt;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor, WIDTH=8.
// Define SERIAL_SUBTRACTOR_OVF_EN to also check ovf.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
  logic         zero;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (b_in),
    .ready(ready),
    .busy (busy),
    .done (done),
    .d    (d),
    .b_out(b_out),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf  (ovf),
`endif
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [W-1:0] aa,
                    input logic [W-1:0] bb,
                    input logic         bi,
                    input logic [W-1:0] ed,
                    input logic         eb,
                    input logic         ez,
                    input logic         eo,
                    input bit           spam);
    logic [W-1:0] pd;
    logic         pb;
    logic         pz;
    pd = d;
    pb = b_out;
    pz = zero;
    @(negedge clk);
    a     = aa;
    b     = bb;
    b_in  = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_busy", busy, 1);
    chk("accept_ready", ready, 0);
    chk("start_hold_d", d, pd);
    chk("start_hold_b", b_out, pb);
    chk("start_hold_z", zero, pz);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (spam) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        b_in  = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      chk(i == W ? "done_hi" : "done_lo", done, (i == W) ? 1 : 0);
      if (i < W) chk("run_hold_d", d, pd);
    end
    chk("d", d, ed);
    chk("b_out", b_out, eb);
    chk("zero", zero, ez);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("ovf", ovf, eo);
`else
    if (eo !== 1'b0) chk("ovf_arg", eo, 0);
`endif
    chk("done_ready", ready, 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_back", ready, 1);
    chk("done_pulse", done, 0);
    chk("busy_lo", busy, 0);
    chk("post_d", d, ed);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_zero", zero, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    op(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    op(8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0, 1'b0);
    op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    op(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a    = W'($urandom);
      b    = W'($urandom);
      b_in = 1'($urandom);
      @(posedge clk);
      #1;
      chk("idle_hold_d", d, 8'h00);
      chk("idle_hold_z", zero, 1);
      chk("idle_done", done, 0);
    end

    op(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    op(8'h05, 8'h07, 1'b1, 8'hFD, 1'b1, 1'b0, 1'b0, 1'b1);

    // abort after four RUN edges
    @(negedge clk);
    a     = 8'h20;
    b     = 8'h50;
    b_in  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_d", d, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", done, 0);
    end
    op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
    op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
